// File: rtl/pwm_receiver.sv
// pwm_receiver: decodes one servo-style PWM input into an 8-bit rate,
// with lock detection and loss-of-signal fail-safe.
//
// state     | meaning
// WAIT_LOW  | after reset or stuck-high error; wait for a settled low input
// WAIT_RISE | idle low, waiting for a rising edge
// HIGH      | pulse in progress, width counter running
// DECODE    | one cycle; classify the measured width
module pwm_receiver #(
  parameter int unsigned GLITCH_US    = 100,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2100,
  parameter int unsigned TIMEOUT_US   = 25000,
  parameter int unsigned LOCK_PULSES  = 3
) (
  input  logic       us_clk,
  input  logic       resetn,
  input  logic       pwm_in,
  output logic [7:0] rate,
  output logic       rate_valid,
  output logic       signal_ok,
  output logic       pulse_err
);
  localparam int unsigned WW = $clog2(MAX_PULSE_US + 2);
  localparam int unsigned LW = $clog2(LOCK_PULSES + 1);
  localparam logic [WW-1:0] W_GLITCH = WW'(GLITCH_US);
  localparam logic [WW-1:0] W_MIN    = WW'(MIN_PULSE_US);
  localparam logic [WW-1:0] W_FULL   = WW'(MIN_PULSE_US + 1020);
  localparam logic [WW-1:0] W_ERR    = WW'(MAX_PULSE_US + 1);
  localparam logic [15:0]   T_LIMIT  = 16'(TIMEOUT_US);
  localparam logic [LW-1:0] L_FULL   = LW'(LOCK_PULSES);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH, DECODE} state_t;

  logic [2:0]    sync_q, sync_d;
  logic [1:0]    fill_q, fill_d;
  state_t        state_q, state_d;
  logic [WW-1:0] width_q, width_d, steps;
  logic [15:0]   tmo_q, tmo_d, tmo_inc;
  logic [LW-1:0] lock_q, lock_d;
  logic [7:0]    rate_q, rate_d, dec_rate;
  logic          rate_valid_q, rate_valid_d;
  logic          signal_ok_q, signal_ok_d;
  logic          pulse_err_q, pulse_err_d;
  logic          s2, s3, rise, fall, accept, tmo_hit;

  assign s2      = sync_q[1];
  assign s3      = sync_q[2];
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

  // Next-state logic: FSM, width measurement, classification, lock and timeout.
  // fill_q keeps WAIT_LOW from trusting the zeroed sync chain right after
  // reset, so a pulse already high at release is never decoded.
  always_comb begin
    sync_d       = {sync_q[1:0], pwm_in};
    fill_d       = {fill_q[0], 1'b1};
    state_d      = state_q;
    width_d      = width_q;
    lock_d       = lock_q;
    rate_d       = rate_q;
    signal_ok_d  = signal_ok_q;
    rate_valid_d = 1'b0;
    pulse_err_d  = 1'b0;
    accept       = 1'b0;
    tmo_d        = tmo_inc;
    steps        = '0;

    if (width_q < W_MIN) begin
      dec_rate = '0;
    end else if (width_q > W_FULL) begin
      dec_rate = 8'hFF;
    end else begin
      steps    = (width_q - W_MIN) >> 2;
      dec_rate = 8'(steps);
    end

    case (state_q)
      WAIT_LOW: begin
        if (fill_q[1] && !s2) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          width_d = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (width_q != W_ERR) width_d = width_q + WW'(1);
        // An over-length pulse wins even if its fall lands on the same cycle.
        if (width_d == W_ERR) begin
          pulse_err_d = 1'b1;
          state_d     = WAIT_LOW;
        end else if (fall) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = WAIT_RISE;
        accept  = (width_q >= W_GLITCH);
        if (rise) begin
          width_d = '0;
          state_d = HIGH;
        end
      end
      default: state_d = WAIT_LOW;
    endcase

    tmo_hit = !accept && (tmo_q != T_LIMIT) && (tmo_inc == T_LIMIT);

    if (accept) begin
      lock_d       = (lock_q == L_FULL) ? lock_q : lock_q + LW'(1);
      signal_ok_d  = (lock_d == L_FULL);
      tmo_d        = '0;
      rate_d       = dec_rate;
      rate_valid_d = 1'b1;
    end
    if (pulse_err_d || tmo_hit) begin
      lock_d      = '0;
      signal_ok_d = 1'b0;
    end
    if (tmo_hit) rate_d = '0;
  end

  // State and output registers.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      sync_q       <= '0;
      fill_q       <= '0;
      state_q      <= WAIT_LOW;
      width_q      <= '0;
      tmo_q        <= '0;
      lock_q       <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      signal_ok_q  <= 1'b0;
      pulse_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      fill_q       <= fill_d;
      state_q      <= state_d;
      width_q      <= width_d;
      tmo_q        <= tmo_d;
      lock_q       <= lock_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      signal_ok_q  <= signal_ok_d;
      pulse_err_q  <= pulse_err_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign signal_ok  = signal_ok_q;
  assign pulse_err  = pulse_err_q;
endmodule

// File: tb/tb_pwm_receiver.sv
// Testbench for pwm_receiver: directed and random pulses against a
// width-based behavioural model of decode, lock and timeout.
`timescale 1ns/1ps
module tb_pwm_receiver;
  localparam int GLITCH = 100;
  localparam int MINP   = 1000;
  localparam int MAXP   = 2100;
  localparam int TMO    = 25000;
  localparam int LOCK   = 3;

  logic       us_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] rate;
  logic       rate_valid, signal_ok, pulse_err;

  int cyc = 0;
  int rv_cnt = 0, rv_rate = 0, rv_time = 0;
  int er_cnt = 0, er_time = 0;
  int checks = 0, passes = 0, fails = 0;

  int m_rate = 0, m_lock = 0, m_last_acc = 0;
  bit m_ok = 1'b0, m_to = 1'b0;

  pwm_receiver dut (
    .us_clk     (us_clk),
    .resetn     (resetn),
    .pwm_in     (pwm_in),
    .rate       (rate),
    .rate_valid (rate_valid),
    .signal_ok  (signal_ok),
    .pulse_err  (pulse_err)
  );

  always #5 us_clk = ~us_clk;

  // cyc equals the number of rising edges so far
  always @(posedge us_clk) cyc <= cyc + 1;

  // strobe monitor, sampled on the falling edge
  always @(negedge us_clk) begin
    if (rate_valid) begin
      rv_cnt  <= rv_cnt + 1;
      rv_rate <= int'(rate);
      rv_time <= cyc;
    end
    if (pulse_err) begin
      er_cnt  <= er_cnt + 1;
      er_time <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_rate(input int w);
    int v;
    if (w < MINP) return 0;
    v = (w - MINP) / 4;
    return (v > 255) ? 255 : v;
  endfunction

  // apply any timeout that has expired by rising edge 'now'
  task automatic sync_timeout(input int now);
    if (!m_to && (now - m_last_acc >= TMO)) begin
      m_to   = 1'b1;
      m_lock = 0;
      m_ok   = 1'b0;
      m_rate = 0;
    end
  endtask

  task automatic do_pulse(input int w, input int gap, input string tag);
    int cs, c0, rv0, er0, t;
    bit exp_rv, exp_er;
    rv0 = rv_cnt; er0 = er_cnt; exp_rv = 1'b0; exp_er = 1'b0;
    @(negedge us_clk);
    cs = cyc;
    pwm_in = 1'b1;
    repeat (w) @(negedge us_clk);
    pwm_in = 1'b0;
    c0 = cyc;
    repeat (gap) @(negedge us_clk);
    #1;
    if (w > MAXP) begin
      exp_er = 1'b1;
      m_lock = 0;
      m_ok   = 1'b0;
    end else if (w >= GLITCH) begin
      t = c0 + 4;
      sync_timeout(t - 1);
      exp_rv     = 1'b1;
      m_rate     = ref_rate(w);
      m_last_acc = t;
      m_to       = 1'b0;
      if (m_lock < LOCK) m_lock++;
      m_ok = (m_lock == LOCK);
    end
    sync_timeout(cyc);
    check({tag, ".strobes"}, rv_cnt - rv0, exp_rv);
    if (exp_rv) begin
      check({tag, ".strobe_rate"}, rv_rate, m_rate);
      check({tag, ".latency"}, rv_time - c0, 4);
    end
    check({tag, ".errs"}, er_cnt - er0, exp_er);
    if (exp_er) check({tag, ".err_time"}, er_time - cs, 2104);
    check({tag, ".rate"}, rate, m_rate);
    check({tag, ".signal_ok"}, signal_ok, m_ok);
  endtask

  task automatic hold_check(input int target, input string tag);
    while (cyc < target) @(negedge us_clk);
    #1;
    sync_timeout(cyc);
    check({tag, ".signal_ok"}, signal_ok, m_ok);
    check({tag, ".rate"}, rate, m_rate);
  endtask

  initial begin
    int widths[10] = '{1000, 1003, 1004, 2020, 2050, 800, 99, 100, 2100, 2101};
    int rv0;

    repeat (5) @(negedge us_clk);
    #1;
    check("rst.rate", rate, 0);
    check("rst.rate_valid", rate_valid, 0);
    check("rst.signal_ok", signal_ok, 0);
    check("rst.pulse_err", pulse_err, 0);
    @(negedge us_clk);
    resetn = 1'b1;
    m_last_acc = cyc;
    repeat (10) @(negedge us_clk);

    for (int i = 0; i < 3; i++) do_pulse(1500, 300, "lock125");

    foreach (widths[i]) do_pulse(widths[i], 100, "width");

    for (int i = 0; i < 3; i++) do_pulse(1500, 150, "prelock");
    do_pulse(5000, 150, "stuck");
    do_pulse(1500, 150, "relock");

    for (int i = 0; i < 3; i++) do_pulse(1800, 150, "lock200");
    do_pulse(50, 150, "glitch");
    rv0 = rv_cnt;
    hold_check(m_last_acc + TMO - 1, "tmo_before");
    hold_check(m_last_acc + TMO, "tmo_at");
    hold_check(m_last_acc + 27000, "tmo_hold");
    check("tmo.no_strobe", rv_cnt - rv0, 0);
    for (int i = 0; i < 3; i++) do_pulse(1800, 150, "after_tmo");

    @(negedge us_clk);
    pwm_in = 1'b1;
    repeat (700) @(negedge us_clk);
    rv0 = rv_cnt;
    resetn = 1'b0;
    #1;
    check("midrst.rate", rate, 0);
    check("midrst.rate_valid", rate_valid, 0);
    check("midrst.signal_ok", signal_ok, 0);
    check("midrst.pulse_err", pulse_err, 0);
    repeat (10) @(negedge us_clk);
    resetn = 1'b1;
    m_rate = 0; m_lock = 0; m_ok = 1'b0; m_to = 1'b0; m_last_acc = cyc;
    repeat (790) @(negedge us_clk);
    pwm_in = 1'b0;
    repeat (300) @(negedge us_clk);
    #1;
    check("midrst.no_strobe", rv_cnt - rv0, 0);
    check("midrst.rate_after", rate, 0);
    do_pulse(1500, 150, "post_reset");

    for (int i = 0; i < 10; i++)
      do_pulse(int'($urandom_range(2300, 0)), int'($urandom_range(300, 20)), "rand");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pwm_receiver.md
Name: pwm_receiver

Overview:
- Decodes one servo-style PWM input, as driven by an RC receiver or the flight controller, back into an 8-bit motor rate.
- Inverse of the motor PWM generation scheme: rate = (high_time_us - MIN_PULSE_US) >> 2, saturated to 0..255.
- Sits at the board input pins, runs on the 1 MHz us_clk, and feeds rate values to the motor command path.
- Provides signal-lock and loss-of-signal fail-safe status.

Parameters:
- GLITCH_US, 100: high pulses shorter than this are ignored entirely.
- MIN_PULSE_US, 1000: high time corresponding to rate 0.
- MAX_PULSE_US, 2100: high time above this is an error pulse.
- TIMEOUT_US, 25000: us without an accepted pulse before signal loss.
- LOCK_PULSES, 3: consecutive accepted pulses required to assert signal_ok.

Ports:
- us_clk  input  1  1 MHz clock; one tick = 1 us.
- resetn  input  1  asynchronous active-low reset.
- pwm_in  input  1  asynchronous PWM input, active high.
- rate  output  8  last decoded rate.
- rate_valid  output  1  one-cycle strobe when rate is updated from an accepted pulse.
- signal_ok  output  1  level; input is locked.
- pulse_err  output  1  one-cycle strobe on an over-length pulse.

Behaviour:
- One clock: us_clk. Reset is asynchronous and active-low (resetn). All flops are reset by resetn.
- Reset values: rate=0, rate_valid=0, signal_ok=0, pulse_err=0, sync chain=0, FSM=WAIT_LOW, all counters=0.
- Input sync: 3-flop chain s1->s2->s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edges are detected using s2/s3 only.
- Width W: the number of consecutive us_clk rising edges at which pwm_in was sampled high. The count is exact with no off-by-one, and the width counter saturates at MAX_PULSE_US+1.
- FSM states:
  - WAIT_LOW: entered after reset and after a stuck-high error. Ignores rise; goes to WAIT_RISE when s2==0. Ensures a partial pulse present at reset is never decoded.
  - WAIT_RISE: on rise, clear the width counter and go to HIGH.
  - HIGH: increment the width counter each cycle.
    - On fall, go to DECODE.
    - If the counter reaches MAX_PULSE_US+1 while still high: pulse_err=1 for one cycle, go to WAIT_LOW. Only one error is raised per stuck-high event.
  - DECODE: one cycle; classify W, then go to WAIT_RISE.
- Classification in DECODE:
  - W < GLITCH_US: ignored. No strobe, no timeout reset, lock count unchanged.
  - GLITCH_US <= W < MIN_PULSE_US: accepted, rate=0.
  - MIN_PULSE_US <= W <= MIN_PULSE_US+1020: accepted, rate=(W-MIN_PULSE_US)>>2 (truncating).
  - MIN_PULSE_US+1020 < W <= MAX_PULSE_US: accepted, rate=255.
  - W > MAX_PULSE_US: not reachable here; handled in HIGH.
- Accepted pulse:
  - rate registered, rate_valid=1 for exactly one cycle, timeout counter cleared.
  - The lock counter increments, saturating at LOCK_PULSES.
  - signal_ok rises in the same cycle the counter reaches LOCK_PULSES.
- Any pulse_err clears the lock counter and drops signal_ok. rate is unchanged.
- Latency: rate/rate_valid update at the 3rd us_clk rising edge after the edge that first samples pwm_in low (2 sync stages + DECODE).
- Timeout:
  - 16-bit counter increments every cycle, saturating.
  - When it reaches TIMEOUT_US: signal_ok=0, lock counter=0, rate forced to 0 (fail-safe). rate_valid is not strobed.
  - Stays in this condition until the next accepted pulse. The accepted pulse restarts locking, but rate is updated immediately.
- Simultaneous events: if an accepted DECODE coincides with the timeout reaching TIMEOUT_US, the accept wins. The timeout is cleared, and rate takes the decoded value.
- Reset mid-pulse: outputs return to reset values immediately (async). After release, the FSM starts in WAIT_LOW, so the truncated pulse is discarded.

Test Plan:
- Reset release with pwm_in low, then 1500 us high pulses every 20000 us:
  - rate_valid strobes with rate=125 each pulse.
  - signal_ok rises on the 3rd strobe.
  - pulse_err never fires.
- Widths 1000, 1003, 1004, 2020, 2050, 800 us: rate = 0, 0, 1, 255, 255, 0. Each gives exactly one rate_valid.
- 50 us glitch between valid pulses:
  - No rate_valid, rate unchanged.
  - The glitch does not clear the timeout counter; a timeout still occurs 25000 us after the last valid pulse if no further valid pulse arrives.
- pwm_in held high 5000 us after lock:
  - pulse_err pulses once at W=2101, signal_ok drops, rate unchanged.
  - The release edge yields no rate_valid.
  - The next 1500 us pulse gives rate=125 and restarts lock.
- Locked at rate=200, then pwm_in held low 30000 us:
  - At 25000 us after the last accept, signal_ok=0 and rate=0.
  - The next 1800 us pulse gives rate=200 immediately, and signal_ok returns after 3 pulses.
- resetn asserted 700 us into a 1500 us pulse, released 10 us later while pwm_in is still high:
  - All outputs are 0 during reset.
  - No rate_valid for the truncated pulse.
  - The following full pulse decodes normally.
